// File: rtl/result_unloader.sv
// Presents a 16-bit result word on the LEDs one byte at a time (low byte first),
// stepping on debounced push-button presses; the 7-seg shows L / H / '-'.
module result_unloader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic        btn,
  output logic [7:0]  byte_out,
  output logic [6:0]  seg_out,
  output logic        word_done
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_L    = 7'h38;
  localparam logic [6:0] SEG_H    = 7'h76;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_SHOW_LO = 2'd1,
    S_SHOW_HI = 2'd2
  } state_e;

  // Handshake: a word transfers on a rising clk edge where word_valid && word_ready;
  // word_ready is high only in S_EMPTY, so at most one transfer per visit to S_EMPTY.
  state_e        state_q, state_d;
  logic [15:0]   word_q, word_d;
  logic          s0_q, s0_d;
  logic          s1_q, s1_d;
  logic          deb_q, deb_d;
  logic          deb_dly_q, deb_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          press;

  always_comb begin
    s0_d      = btn;
    s1_d      = s0_q;
    deb_dly_d = deb_q;
    deb_d     = deb_q;
    cnt_d     = '0;
    // The level must disagree for DEBOUNCE_CYCLES consecutive samples before it is accepted.
    if (s1_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press = deb_q & ~deb_dly_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    done_d  = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (word_valid) begin
          word_d  = word_in;
          state_d = S_SHOW_LO;
        end
      end
      S_SHOW_LO: begin
        if (press) state_d = S_SHOW_HI;
      end
      S_SHOW_HI: begin
        if (press) begin
          state_d = S_EMPTY;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    word_ready = 1'b0;
    byte_out   = 8'h00;
    seg_out    = SEG_DASH;
    case (state_q)
      S_EMPTY:   word_ready = 1'b1;
      S_SHOW_LO: begin
        byte_out = word_q[7:0];
        seg_out  = SEG_L;
      end
      S_SHOW_HI: begin
        byte_out = word_q[15:8];
        seg_out  = SEG_H;
      end
      default: ;
    endcase
  end

  assign word_done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      word_q    <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

endmodule
